// File: rtl/spi_slave.sv
// SPI mode-0 slave endpoint (MSB first). Pins are oversampled into the clk domain;
// received words come out as rx_valid pulses, transmit words come in through a holding register.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err,
  output logic              tx_underrun,
  output logic              state_dbg
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state, state_n;
  logic                sck_s1, sck_s2, sck_d;
  logic                ss_s1, ss_s2, ss_d;
  logic                mosi_s1, mosi_s2;
  logic [1:0]          fill_cnt;
  logic                armed;
  logic                sck_rise, sck_fall, ss_fall, ss_rise;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]   rx_shift, rx_shift_n, rx_data_n;
  logic [DATA_W-1:0]   tx_shift, tx_shift_n;
  logic [DATA_W-1:0]   hold_data, hold_data_n;
  logic                hold_full, hold_full_n;
  logic                miso_q, miso_n;
  logic                word_done, word_done_n;
  logic                pend_ur, pend_ur_n;
  logic                rx_valid_n, frame_err_n, tx_underrun_n;
  logic                fetch, fetch_defer;

  // ss edges only count once the pipeline holds real pin samples and ss has been seen high,
  // so a select held low across reset release does not look like a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_d    <= 1'b0;
      ss_s1    <= 1'b1;
      ss_s2    <= 1'b1;
      ss_d     <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd3 && ss_d) armed <= 1'b1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign ss_fall  = ~ss_s2 & ss_d & armed;
  assign ss_rise  = ss_s2 & ~ss_d;

  // Handshake: a tx word transfers on a clk edge where tx_valid & tx_ready are both 1;
  // tx_ready is simply "holding register empty" and does not depend on tx_valid.
  assign tx_ready  = ~hold_full;
  assign miso      = miso_q & ~ss_s2;
  assign state_dbg = (state == ACTIVE);

  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    rx_shift_n    = rx_shift;
    rx_data_n     = rx_data;
    rx_valid_n    = 1'b0;
    tx_shift_n    = tx_shift;
    hold_data_n   = hold_data;
    hold_full_n   = hold_full;
    miso_n        = miso_q;
    word_done_n   = word_done;
    pend_ur_n     = pend_ur;
    frame_err_n   = 1'b0;
    tx_underrun_n = 1'b0;
    fetch         = 1'b0;
    fetch_defer   = 1'b0;

    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n     = ACTIVE;
          bit_cnt_n   = '0;
          word_done_n = 1'b0;
          pend_ur_n   = 1'b0;
          fetch       = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_n     = IDLE;
          frame_err_n = (bit_cnt != '0);
          miso_n      = 1'b0;
          bit_cnt_n   = '0;
          word_done_n = 1'b0;
          pend_ur_n   = 1'b0;
          tx_shift_n  = '0;
        end else if (sck_rise) begin
          rx_shift_n = {rx_shift[DATA_W-2:0], mosi_s2};
          // An empty reload at a word boundary only counts once the next word really starts.
          if (pend_ur) begin
            tx_underrun_n = 1'b1;
            pend_ur_n     = 1'b0;
          end
          if (bit_cnt == LAST_BIT) begin
            rx_data_n   = rx_shift_n;
            rx_valid_n  = 1'b1;
            bit_cnt_n   = '0;
            word_done_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else if (sck_fall) begin
          if (word_done) begin
            fetch       = 1'b1;
            fetch_defer = 1'b1;
            word_done_n = 1'b0;
          end else begin
            tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
            miso_n     = tx_shift[DATA_W-2];
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (fetch) begin
      if (hold_full) begin
        tx_shift_n  = hold_data;
        hold_full_n = 1'b0;
        miso_n      = hold_data[DATA_W-1];
      end else begin
        tx_shift_n = '0;
        miso_n     = 1'b0;
        if (fetch_defer) pend_ur_n = 1'b1;
        else             tx_underrun_n = 1'b1;
      end
    end

    if (tx_valid && !hold_full) begin
      hold_data_n = tx_data;
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      miso_q      <= 1'b0;
      word_done   <= 1'b0;
      pend_ur     <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      rx_shift    <= rx_shift_n;
      rx_data     <= rx_data_n;
      rx_valid    <= rx_valid_n;
      tx_shift    <= tx_shift_n;
      hold_data   <= hold_data_n;
      hold_full   <= hold_full_n;
      miso_q      <= miso_n;
      word_done   <= word_done_n;
      pend_ur     <= pend_ur_n;
      frame_err   <= frame_err_n;
      tx_underrun <= tx_underrun_n;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the SPI master (sck half-period 4 clk)
// and checks received words, miso bits and the status pulses.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, ss, mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_err, tx_underrun, state_dbg;

  int tests = 0;
  int fails = 0;
  int rx_cnt = 0;
  int fe_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] exp_q[$];

  spi_slave #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .frame_err(frame_err), .tx_underrun(tx_underrun),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard on received words and pulse counters
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
      else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frame_err) fe_cnt++;
    if (tx_underrun) ur_cnt++;
  end

  // driver tasks
  task automatic preload(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("preload_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_load", 32'(tx_ready), 32'd0);
  endtask

  task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      repeat (4) @(negedge clk);
      got = {got[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk);
    ss = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic       pre;
    logic [7:0] tx;
    logic [7:0] mosi_w;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_ur;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] got, got2;
    int r0, f0, u0;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 0};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 0};
    vecs[3] = '{1'b0, 8'h00, 8'hC3, 8'hC3, 8'h00, 1};
    vecs[4] = '{1'b1, 8'h96, 8'h69, 8'h69, 8'h96, 0};

    // reset
    rst = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // single-word frames from the vector table
    for (int v = 0; v < 5; v++) begin
      r0 = rx_cnt; f0 = fe_cnt; u0 = ur_cnt;
      if (vecs[v].pre) preload(vecs[v].tx);
      exp_q.push_back(vecs[v].exp_rx);
      ss = 1'b0;
      spi_bits(vecs[v].mosi_w, 8, got);
      ss_high();
      check($sformatf("v%0d_miso_bits", v), 32'(got), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d_rx_count", v), 32'(rx_cnt - r0), 32'd1);
      check($sformatf("v%0d_underrun", v), 32'(ur_cnt - u0), 32'(vecs[v].exp_ur));
      check($sformatf("v%0d_frame_err", v), 32'(fe_cnt - f0), 32'd0);
      check($sformatf("v%0d_miso_idle", v), 32'(miso), 32'd0);
      check($sformatf("v%0d_sb_drained", v), 32'(exp_q.size()), 32'd0);
    end

    // two words in one frame
    r0 = rx_cnt; f0 = fe_cnt; u0 = ur_cnt;
    preload(8'h81);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hF0);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    check("two_fetch_ready", 32'(tx_ready), 32'd1);
    preload(8'h7E);
    spi_bits(8'h12, 8, got);
    spi_bits(8'hF0, 8, got2);
    ss_high();
    check("two_miso_w0", 32'(got), 32'h81);
    check("two_miso_w1", 32'(got2), 32'h7E);
    check("two_rx_count", 32'(rx_cnt - r0), 32'd2);
    check("two_underrun", 32'(ur_cnt - u0), 32'd0);
    check("two_frame_err", 32'(fe_cnt - f0), 32'd0);

    // mid-word abort, then a clean frame
    r0 = rx_cnt; f0 = fe_cnt; u0 = ur_cnt;
    preload(8'h99);
    ss = 1'b0;
    spi_bits(8'hAA, 5, got);
    ss_high();
    check("abort_frame_err", 32'(fe_cnt - f0), 32'd1);
    check("abort_rx_count", 32'(rx_cnt - r0), 32'd0);
    check("abort_miso", 32'(miso), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    preload(8'h6A);
    exp_q.push_back(8'h55);
    ss = 1'b0;
    spi_bits(8'h55, 8, got);
    ss_high();
    check("after_abort_miso", 32'(got), 32'h6A);
    check("after_abort_rx_count", 32'(rx_cnt - r0), 32'd1);
    check("after_abort_frame_err", 32'(fe_cnt - f0), 32'd1);

    // reset mid-frame with ss held low
    r0 = rx_cnt; f0 = fe_cnt; u0 = ur_cnt;
    preload(8'h12);
    ss = 1'b0;
    spi_bits(8'hFF, 3, got);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_state", 32'(state_dbg), 32'd0);
    check("rstmid_tx_ready", 32'(tx_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("rstmid_still_idle", 32'(state_dbg), 32'd0);
    check("rstmid_no_rx", 32'(rx_cnt - r0), 32'd0);
    check("rstmid_no_underrun", 32'(ur_cnt - u0), 32'd0);
    check("rstmid_no_frame_err", 32'(fe_cnt - f0), 32'd0);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    preload(8'hE7);
    exp_q.push_back(8'h0F);
    ss = 1'b0;
    spi_bits(8'h0F, 8, got);
    ss_high();
    check("rstmid_next_miso", 32'(got), 32'hE7);
    check("rstmid_next_rx_count", 32'(rx_cnt - r0), 32'd1);
    check("rstmid_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
